regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised MIPS-style register file with an integrated pending-write scoreboard.
//  - Two combinational read ports and one clocked write port.
//  - Register 0 is hardwired to zero; the stack-pointer index has a configurable reset value.
//  - Per-register busy bits are set at issue and cleared at writeback.
//  - The decode stage uses the busy outputs for hazard stalls; pipeline flush clears them.
// PARAMETERS
//  DATA_W   32        register width in bits
//  ADDR_W   5         register index width; NUM_REGS = 1<<ADDR_W
//  SP_IDX   29        index loaded with SP_INIT on reset (must be nonzero)
//  SP_INIT  32'h80    reset value of register SP_IDX; all other registers reset to 0
// PORTS
//  clk          in   1          clock, all state updates on rising edge
//  reset        in   1          asynchronous, active-high reset
//  RegWrite     in   1          writeback enable
//  Write_reg    in   ADDR_W     writeback index
//  Write_data   in   DATA_W     writeback data
//  Read_reg1    in   ADDR_W     read port 1 index
//  Read_reg2    in   ADDR_W     read port 2 index
//  Read_data1   out  DATA_W     read port 1 data
//  Read_data2   out  DATA_W     read port 2 data
//  issue_valid  in   1          an instruction writing issue_rd has issued
//  issue_rd     in   ADDR_W     destination index of the issued instruction
//  flush        in   1          clear all busy bits (pipeline squash)
//  busy1        out  1          Read_reg1 has a pending write
//  busy2        out  1          Read_reg2 has a pending write
//  busy_cnt     out  ADDR_W+1   number of registers currently busy
// BEHAVIOUR
//  - Reset (async, mid-operation too):
//    - All registers cleared to 0, except SP_IDX = SP_INIT.
//    - All busy bits = 0 and busy_cnt = 0.
//    - Read outputs reflect the reset contents immediately.
//  - Reads are combinational, zero latency. Index 0 always returns 0 and busy=0.
//  - Write: on posedge, if RegWrite && Write_reg!=0, then Write_data is stored. Writes to index 0 are ignored.
//  - Busy bits, evaluated per posedge in this priority order:
//    1. flush=1: all bits are cleared, and issue/writeback in the same cycle do not set any bit.
//    2. Writeback (RegWrite && Write_reg!=0) clears busy[Write_reg].
//    3. issue_valid && issue_rd!=0 sets busy[issue_rd].
//    - If the issue and writeback indices are equal in the same cycle, the set wins (a newer producer is in flight).
//  - busy_cnt is updated incrementally and always equals popcount(busy):
//    - +1 only when a clear bit becomes set.
//    - -1 only when a set bit becomes clear.
//    - A set and a clear on different indices in the same cycle give a net change of 0.
//    - Re-issuing to an already-busy register leaves the count unchanged.
//    - Writeback to a non-busy register leaves the count unchanged.
//    - flush loads 0.
//    - The count never wraps, because its maximum is NUM_REGS-1.
//  - Writeback to a register that is not busy is legal: the data is written and the busy state is unchanged.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//    - When RegWrite=1 and Write_reg == Read_regN != 0 in the same cycle, Read_dataN = Write_data and busyN = 0, unless issue_rd in that same cycle equals the index with issue_valid=1 (then busyN = 1).
//  RF_BYPASS_EN undefined:
//    - Read_dataN always returns the stored value and busyN the registered bit.
//    - The new data and busy state become visible from the cycle after the write edge.
// TESTING
//  - Reset: assert reset mid-run -> Read_data of index 29 = 0x80, all other indices = 0, busy_cnt = 0, busy1 = busy2 = 0, all without waiting for a clock edge.
//  - Zero register: write 0xDEADBEEF to index 0 and issue_rd=0 -> reading index 0 returns 0, busy = 0, busy_cnt unchanged.
//  - Scoreboard: issue rd=5, then rd=7 -> busy_cnt = 2, busy1 = 1 for Read_reg1=5; writeback index 5 with 0x1234 -> busy_cnt = 1, reading index 5 = 0x1234.
//  - Collision: index 9 busy; issue rd=9 and writeback index 9 in the same cycle -> busy[9] stays 1, busy_cnt unchanged.
//  - Flush: three registers busy; flush together with issue rd=3 -> busy_cnt = 0 next cycle and index 3 not busy.
//  - Bypass: Read_reg1=4, RegWrite=1, Write_reg=4, Write_data=0xA5A5 -> with RF_BYPASS_EN, Read_data1 = 0xA5A5 in the same cycle; without it, the old value is returned and 0xA5A5 is returned the next cycle.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: MIPS-style register file with an integrated
// pending-write scoreboard.
//   - Two combinational read ports and one clocked write port.
//   - Register 0 is hardwired to zero.
//   - Register SP_IDX resets to SP_INIT. Every other register resets to 0.
//   - A busy bit per register is set when an instruction issues and cleared
//     at writeback. A flush clears all busy bits.
//   - busy_cnt is maintained incrementally and tracks popcount(busy).
// Optional feature (macro RF_BYPASS_EN):
//   A write in the current cycle is forwarded to a read port that reads the
//   same nonzero index. The forwarded busy flag follows the same rule. When
//   the macro is undefined, reads return the stored state only.
module regfile_scoreboard #(
   parameter int                DATA_W  = 32,
   parameter int                ADDR_W  = 5,
   parameter int                SP_IDX  = 29,
   parameter logic [DATA_W-1:0] SP_INIT = 32'h80
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] Write_reg,
   input  logic [DATA_W-1:0] Write_data,
   input  logic [ADDR_W-1:0] Read_reg1,
   input  logic [ADDR_W-1:0] Read_reg2,
   output logic [DATA_W-1:0] Read_data1,
   output logic [DATA_W-1:0] Read_data2,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rd,
   input  logic              flush,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int CNT_W    = ADDR_W + 1;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                wb_en;
   logic                iss_en;
   logic                cnt_inc;
   logic                cnt_dec;

   // Register 0 is never written. It is also never marked busy.
   assign wb_en  = RegWrite && (Write_reg != '0);
   assign iss_en = issue_valid && (issue_rd != '0);

   // Architectural register storage. The array resets to its defined contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the whole array is reset because software relies on a known
         // stack pointer and zeroed registers straight out of reset.
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
         end
      end else if (wb_en) begin
         // NOTE: non-blocking assignment, so every sequential element samples
         // the values that were present before the edge.
         regs[Write_reg] <= Write_data;
      end
   end

   // Next busy vector. Priority: flush, then the set from issue, then the
   // clear from writeback. The set overrides the clear when both hit one index.
   always_comb begin
      // NOTE: each variable gets a default first, so no path can infer a latch.
      busy_nxt = busy;
      if (wb_en) begin
         busy_nxt[Write_reg] = 1'b0;
      end
      if (iss_en) begin
         busy_nxt[issue_rd] = 1'b1;
      end
      if (flush) begin
         busy_nxt = '0;
      end
   end

   // Incremental count. Each term fires only on a real bit transition.
   always_comb begin
      cnt_inc = iss_en && !busy[issue_rd];
      cnt_dec = wb_en && busy[Write_reg] && !(iss_en && (issue_rd == Write_reg));
      cnt_nxt = busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      if (flush) begin
         cnt_nxt = '0;
      end
   end

   // Scoreboard state: the busy bits and their running count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

   // Read port 1: stored value, with optional same-cycle write forwarding.
   always_comb begin
      Read_data1 = regs[Read_reg1];
      busy1      = busy[Read_reg1];
`ifdef RF_BYPASS_EN
      if (wb_en && (Write_reg == Read_reg1)) begin
         Read_data1 = Write_data;
         busy1      = iss_en && (issue_rd == Read_reg1);
      end
`endif
      if (Read_reg1 == '0) begin
         Read_data1 = '0;
         busy1      = 1'b0;
      end
   end

   // Read port 2: same behaviour as read port 1.
   always_comb begin
      Read_data2 = regs[Read_reg2];
      busy2      = busy[Read_reg2];
`ifdef RF_BYPASS_EN
      if (wb_en && (Write_reg == Read_reg2)) begin
         Read_data2 = Write_data;
         busy2      = iss_en && (issue_rd == Read_reg2);
      end
`endif
      if (Read_reg2 == '0) begin
         Read_data2 = '0;
         busy2      = 1'b0;
      end
   end

endmodule
